// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller.
// A single 1-bit full-adder cell is reused once per bit position, LSB first.
// Subtraction is done as A + ~B + 1: the inverted B is latched and the carry
// flop is preloaded with 1.
//
// state  | meaning
// IDLE   | waiting for start; R, C_O and V hold the last result
// RUN    | one operand bit pair per cycle through the adder cell
// DONE   | one-cycle completion pulse, then back to IDLE

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);
  // Plain combinational full adder.
  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic             C_O,
  output logic             V
);
  // One extra bit so the counter reaches WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum;
  logic             cout;
  logic             last_bit;

  // The shift registers move right, so bit 0 always holds operand bit[cnt].
  fa_cell u_fa (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .carry_in  (carry),
    .sum       (sum),
    .carry_out (cout)
  );

  assign last_bit = (cnt == LAST_BIT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // Operand capture, per-bit shift/accumulate and flag capture on the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      R     <= '0;
      C_O   <= 1'b0;
      V     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= op ? ~B : B;
            carry <= op;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          R     <= {sum, R[WIDTH-1:1]};
          carry <= cout;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            // carry still holds the carry into the MSB here.
            C_O <= cout;
            V   <= carry ^ cout;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: a 32-bit instance for directed and random
// traffic, and a 4-bit instance swept over every operand pair.
// An arithmetic reference model predicts busy/done timing and the result.

module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start1, op1, busy1, done1, co1, v1;
  logic [31:0] a1, b1, r1;
  logic        start2, op2, busy2, done2, co2, v2;
  logic [3:0]  a2, b2, r2;

  serial_adder_ctrl #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .R(r1), .C_O(co1), .V(v1));

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start2), .op(op2), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .R(r2), .C_O(co2), .V(v2));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {V, C_O, R}.
  function automatic logic [65:0] ref_calc(input int w, input logic [63:0] a_in,
                                           input logic [63:0] b_in, input logic op);
    logic [63:0] mask, a, b, res;
    logic [64:0] full;
    logic        c, v, sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    if (!op) begin
      full = {1'b0, a} + {1'b0, b};
      res  = full[63:0] & mask;
      c    = full[w];
      sa = a[w-1]; sb = b[w-1]; sr = res[w-1];
      v    = (sa == sb) && (sr != sa);
    end else begin
      res  = (a - b) & mask;
      c    = (a >= b);
      sa = a[w-1]; sb = b[w-1]; sr = res[w-1];
      v    = (sa != sb) && (sr != sa);
    end
    return {v, c, res};
  endfunction

  // Model state per instance: cycles until back in idle, pending and visible result.
  int          cyc_left [2];
  logic [63:0] exp_r [2];
  logic [63:0] pend_r [2];
  logic        exp_c [2], exp_v [2], pend_c [2], pend_v [2];
  bit          armed = 1'b0;

  task automatic model_step(input int i, input int w, input logic st, input logic op,
                            input logic [63:0] a, input logic [63:0] b);
    logic [65:0] rv;
    if (reset) begin
      cyc_left[i] = 0;
      exp_r[i] = '0; exp_c[i] = 1'b0; exp_v[i] = 1'b0;
    end else if (cyc_left[i] == 0) begin
      if (st) begin
        rv = ref_calc(w, a, b, op);
        pend_v[i] = rv[65]; pend_c[i] = rv[64]; pend_r[i] = rv[63:0];
        cyc_left[i] = w + 1;
      end
    end else begin
      if (cyc_left[i] == 2) begin
        exp_r[i] = pend_r[i]; exp_c[i] = pend_c[i]; exp_v[i] = pend_v[i];
      end
      cyc_left[i] = cyc_left[i] - 1;
    end
  endtask

  // Advance the model on every rising edge with the inputs the DUTs sample.
  always @(posedge clk) begin
    if (reset) armed = 1'b1;
    model_step(0, 32, start1, op1, {32'd0, a1}, {32'd0, b1});
    model_step(1, 4, start2, op2, {60'd0, a2}, {60'd0, b2});
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    if (armed) begin
      chk("busy32", {63'd0, busy1}, {63'd0, cyc_left[0] >= 2});
      chk("done32", {63'd0, done1}, {63'd0, cyc_left[0] == 1});
      chk("busy4",  {63'd0, busy2}, {63'd0, cyc_left[1] >= 2});
      chk("done4",  {63'd0, done2}, {63'd0, cyc_left[1] == 1});
      if (cyc_left[0] < 2) begin
        chk("r32",  {32'd0, r1}, exp_r[0]);
        chk("co32", {63'd0, co1}, {63'd0, exp_c[0]});
        chk("v32",  {63'd0, v1}, {63'd0, exp_v[0]});
      end
      if (cyc_left[1] < 2) begin
        chk("r4",  {60'd0, r2}, exp_r[1]);
        chk("co4", {63'd0, co2}, {63'd0, exp_c[1]});
        chk("v4",  {63'd0, v2}, {63'd0, exp_v[1]});
      end
    end
  end

  // One 32-bit operation with hand-computed expectations and latency check.
  task automatic run32(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [31:0] er, input logic ec, input logic ev);
    int n;
    start1 = 1'b1; a1 = a; b1 = b; op1 = op;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'd33);
    chk({name, "_r"}, {32'd0, r1}, {32'd0, er});
    chk({name, "_co"}, {63'd0, co1}, {63'd0, ec});
    chk({name, "_v"}, {63'd0, v1}, {63'd0, ev});
    @(negedge clk);
  endtask

  initial begin
    int dcount;
    logic [65:0] pin;
    reset = 1'b1;
    start1 = 1'b0; op1 = 1'b0; a1 = '0; b1 = '0;
    start2 = 1'b0; op2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, busy1}, 64'd0);
    chk("reset_r", {32'd0, r1}, 64'd0);
    reset = 1'b0;

    pin = ref_calc(32, 64'h3, 64'h5, 1'b1);
    chk("model_sub", {62'd0, pin[65:64]}, 64'd0);
    chk("model_sub_r", pin[63:0], 64'hFFFF_FFFE);
    pin = ref_calc(4, 64'h7, 64'h1, 1'b0);
    chk("model_ovf4", {62'd0, pin[65:64]}, 64'd2);

    run32("add", 32'h5, 32'h3, 1'b0, 32'h8, 1'b0, 1'b0);
    run32("carry", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    run32("ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run32("sub_borrow", 32'h3, 32'h5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run32("sub_ovf", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Restarts at E5 and at the DONE edge must be ignored.
    start1 = 1'b1; a1 = 32'h5; b1 = 32'h3; op1 = 1'b0;
    dcount = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done1) dcount++;
      start1 = 1'b0;
      if (k == 5 || done1) begin
        start1 = 1'b1; a1 = 32'h1234_5678; b1 = 32'h1111_1111; op1 = 1'b1;
      end
    end
    start1 = 1'b0;
    chk("ignore_done_count", 64'(dcount), 64'd1);
    chk("ignore_r", {32'd0, r1}, 64'd8);
    chk("ignore_idle", {63'd0, busy1}, 64'd0);

    // Reset at E10 aborts the operation.
    start1 = 1'b1; a1 = 32'h7; b1 = 32'h9; op1 = 1'b0;
    dcount = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done1) dcount++;
      start1 = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {63'd0, busy1}, 64'd0);
    chk("abort_r", {32'd0, r1}, 64'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done1) dcount++;
    end
    chk("abort_no_done", 64'(dcount), 64'd0);
    run32("after_abort", 32'h2, 32'h2, 1'b0, 32'h4, 1'b0, 1'b0);

    // Random traffic including starts while busy and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      start1 = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: a1 = 32'hFFFF_FFFF;
        1: a1 = 32'h8000_0000;
        default: a1 = $urandom;
      endcase
      b1 = ($urandom_range(0, 4) == 0) ? 32'h7FFF_FFFF : $urandom;
      op1 = $urandom_range(0, 1) == 1;
      reset = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    start1 = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);

    // Every 4-bit operand pair for both ops, one start every 6 cycles.
    for (int o = 0; o < 2; o++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          start2 = 1'b1; a2 = 4'(a); b2 = 4'(b); op2 = (o == 1);
          @(negedge clk);
          start2 = 1'b0;
          a2 = 4'($urandom); b2 = 4'($urandom);
          repeat (5) @(negedge clk);
        end
      end
    end
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin an operation, sampled on the rising edge of clk.
REQ-005 The block SHALL have port op, input, 1 bit: 0 = add, 1 = subtract (A - B), sampled with start.
REQ-006 The block SHALL have ports A and B, input, WIDTH bits each: the operands, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while bits are being computed.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-009 The block SHALL have port R, output, WIDTH bits: the result register.
REQ-010 The block SHALL have port C_O, output, 1 bit: the carry out of the MSB.
REQ-011 The block SHALL have port V, output, 1 bit: the signed overflow flag.

Function
REQ-012 The block SHALL compute with exactly one 1-bit full-adder cell (sum, carry_out, a, b, carry_in), reused once per bit; no WIDTH-bit adder is permitted.
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1 at edge E0, the block SHALL latch A, op, and B (B inverted when op=1) into shift registers, set the carry flop to op, clear the bit counter to 0, and enter RUN; with start=0 it SHALL remain in IDLE.
REQ-015 In RUN, each edge SHALL feed operand bit[counter] and the carry flop to the cell, shift the sum into the result register LSB-first, update the carry flop, and increment the counter.
REQ-016 Bits 0..WIDTH-1 SHALL be processed on edges E1..EWIDTH; at EWIDTH the FSM SHALL enter DONE, and R, C_O and V SHALL become valid.
REQ-017 C_O SHALL equal the final carry; V SHALL equal (carry into the MSB) XOR (carry out of the MSB).
REQ-018 In subtract mode, C_O=1 SHALL mean no borrow (A >= B unsigned).
REQ-019 DONE SHALL last exactly one cycle, with done=1 and busy=0, and then return to IDLE; done=0 in every other state.
REQ-020 busy SHALL be 1 exactly in RUN.
REQ-021 Latency from start-sampling edge to done high SHALL be WIDTH+1 edges; minimum start-to-start period SHALL be WIDTH+2 cycles.
REQ-022 start asserted in RUN or DONE SHALL be ignored (not queued), and operand input changes during RUN SHALL have no effect.
REQ-023 R, C_O and V SHALL hold their values from DONE until the next accepted start; during RUN, R holds the partial shift contents and is not valid.
REQ-024 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap within an operation.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE and clear counter, carry flop, shift registers, R, C_O, V, busy and done to 0, taking priority over start.
REQ-026 reset asserted mid-RUN SHALL abort the operation with no done pulse, and start is accepted on the first edge with reset=0.

Verification
REQ-027 Add (WIDTH=32): A=0x00000005, B=0x00000003, op=0 -> done after 33 edges, R=0x00000008, C_O=0, V=0.
REQ-028 Carry/overflow: A=0xFFFFFFFF, B=0x00000001, op=0 -> R=0, C_O=1, V=0; A=0x7FFFFFFF, B=1, op=0 -> R=0x80000000, C_O=0, V=1.
REQ-029 Subtract: A=3, B=5, op=1 -> R=0xFFFFFFFE, C_O=0, V=0; A=0x80000000, B=1, op=1 -> R=0x7FFFFFFF, C_O=1, V=1.
REQ-030 Busy-ignore: start pulsed again at edges E5 and DONE with new operands -> first result unchanged, exactly one done pulse, and the block returns to IDLE.
REQ-031 Reset mid-operation: reset at E10 -> next cycle busy=0, R=0, no done pulse; a following start of 2+2 -> R=4 after 33 edges.
REQ-032 Exhaustive small width: WIDTH=4, all 256 A/B pairs x both op values, back-to-back every 6 cycles -> R, C_O and V match reference arithmetic.
